// File: rtl/speech_pkg.sv
// Shared definitions for the speech sequencer: word codes, flash address
// table and sequencer state encoding.
package speech_pkg;

    localparam int NUM_WORDS = 32'd18;

    localparam logic [4:0] W_ZERO  = 5'd0,  W_ONE    = 5'd1,  W_TWO    = 5'd2,  W_THREE  = 5'd3;
    localparam logic [4:0] W_FOUR  = 5'd4,  W_FIVE   = 5'd5,  W_SIX    = 5'd6,  W_SEVEN  = 5'd7;
    localparam logic [4:0] W_EIGHT = 5'd8,  W_NINE   = 5'd9,  W_PLUS   = 5'd10, W_MINUS  = 5'd11;
    localparam logic [4:0] W_TIMES = 5'd12, W_DIVIDE = 5'd13, W_EQUALS = 5'd14, W_POINT  = 5'd15;
    localparam logic [4:0] W_NEGATIVE = 5'd16, W_ERROR = 5'd17;

    // Each word occupies an 8 KiB slot in flash, starting at 0x004000.
    localparam logic [23:0] WORD_START [NUM_WORDS] = '{
        24'h004000, 24'h006000, 24'h008000, 24'h00A000, 24'h00C000, 24'h00E000,
        24'h010000, 24'h012000, 24'h014000, 24'h016000, 24'h018000, 24'h01A000,
        24'h01C000, 24'h01E000, 24'h020000, 24'h022000, 24'h024000, 24'h026000
    };

    localparam logic [23:0] WORD_END [NUM_WORDS] = '{
        24'h005FFF, 24'h007FFF, 24'h009FFF, 24'h00BFFF, 24'h00DFFF, 24'h00FFFF,
        24'h011FFF, 24'h013FFF, 24'h015FFF, 24'h017FFF, 24'h019FFF, 24'h01BFFF,
        24'h01DFFF, 24'h01FFFF, 24'h021FFF, 24'h023FFF, 24'h025FFF, 24'h027FFF
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_PLAY  = 2'd2,
        S_GAP   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/word_fifo.sv
// Circular word-code queue with registered count/full and a combinational
// head-of-queue output.
module word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(32'd1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(32'd1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_nxt_s;
    logic             full_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop and compute the next occupancy; flush wins over both.
    always_comb begin
        push_ok_s = push && !full_r && !flush;
        pop_ok_s  = pop && (count_r != '0) && !flush;
        if (flush) begin
            count_nxt_s = '0;
        end else if (push_ok_s && !pop_ok_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (!push_ok_s && pop_ok_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointer, occupancy and full-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
        end
    end

    // Storage array, cleared on reset so the head never presents stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_r;

endmodule

// File: rtl/speech_sequencer.sv
// Plays queued word codes back-to-back through the audio controller with a
// fixed silence gap between words.
module speech_sequencer
    import speech_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int WORD_W     = 5,
    parameter int GAP_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WORD_W-1:0]             word,
    input  logic                          flush,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic [23:0]                   start_address,
    output logic [23:0]                   end_address,
    output logic                          play_start,
    input  logic                          play_finish
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(32'd1);

    seq_state_e                     state_r;
    seq_state_e                     next_state_s;
    logic [WORD_W-1:0]              head_s;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count_s;
    logic                           pop_s;
    logic                           load_s;
    logic                           code_valid_s;
    logic [GAP_W-1:0]               gap_cnt_r;
    logic [23:0]                    start_address_r;
    logic [23:0]                    end_address_r;
    logic                           play_start_r;

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_word_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (word),
        .pop   (pop_s),
        .flush (flush),
        .full  (full),
        .count (fifo_count_s),
        .rdata (head_s)
    );

    assign code_valid_s = (32'(head_s) < NUM_WORDS);

    // Next-state logic; invalid codes are popped and dropped without playback.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if ((fifo_count_s != '0) && !flush) begin
                    pop_s = 1'b1;
                    if (code_valid_s) begin
                        load_s       = 1'b1;
                        next_state_s = S_START;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_START: begin
                if (!play_finish) next_state_s = S_PLAY;
                else              next_state_s = S_START;
            end
            S_PLAY: begin
                if (play_finish) next_state_s = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                else             next_state_s = S_PLAY;
            end
            S_GAP: begin
                if (gap_cnt_r == GAP_LAST) next_state_s = S_IDLE;
                else                       next_state_s = S_GAP;
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register and start strobe, registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            play_start_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            play_start_r <= (next_state_s == S_START);
        end
    end

    // Gap counter runs only while in GAP and restarts from zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt_r <= '0;
        end else if ((state_r == S_GAP) && (gap_cnt_r != GAP_LAST)) begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
        end else begin
            gap_cnt_r <= '0;
        end
    end

    // Address registers hold from the START entry until the next valid pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_address_r <= 24'h000000;
            end_address_r   <= 24'h000000;
        end else if (load_s) begin
            start_address_r <= WORD_START[head_s];
            end_address_r   <= WORD_END[head_s];
        end
    end

    assign start_address = start_address_r;
    assign end_address   = end_address_r;
    assign play_start    = play_start_r;
    assign count         = fifo_count_s;
    assign busy          = (state_r != S_IDLE) || (fifo_count_s != '0);

endmodule

// File: tb/tb_speech_sequencer.sv
// Directed self-checking bench for speech_sequencer with a hand-driven
// audio-controller handshake.
module tb_speech_sequencer;

    localparam int GAP = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push;
    logic [4:0]  word;
    logic        flush;
    logic        full;
    logic [3:0]  count;
    logic        busy;
    logic [23:0] start_address;
    logic [23:0] end_address;
    logic        play_start;
    logic        play_finish;

    int   vectors = 0;
    int   miscompares = 0;
    int   starts = 0;
    logic ps_d = 1'b0;
    int   k;
    int   base;
    int   codes [9] = '{32'd1, 32'd2, 32'd4, 32'd5, 32'd6, 32'd8, 32'd9, 32'd10, 32'd11};

    speech_sequencer #(
        .FIFO_DEPTH (8),
        .WORD_W     (5),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .word          (word),
        .flush         (flush),
        .full          (full),
        .count         (count),
        .busy          (busy),
        .start_address (start_address),
        .end_address   (end_address),
        .play_start    (play_start),
        .play_finish   (play_finish)
    );

    always #10 clk = ~clk;

    // Counts rising edges of play_start as observed by the audio controller.
    always @(posedge clk) begin
        ps_d <= play_start;
        if (play_start && !ps_d) starts <= starts + 1;
    end

    function automatic logic [23:0] saddr(input int c);
        return 24'h004000 + 24'(c) * 24'h002000;
    endfunction

    function automatic logic [23:0] eaddr(input int c);
        return saddr(c) + 24'h001FFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int c);
        push = 1'b1;
        word = 5'(c);
        tick();
        push = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!play_start && n < 400);
        if (!play_start) check("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 400);
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Entered on the cycle play_start is first seen high.
    task automatic play_cycle(input int len);
        tick();
        check("ps_hold", 32'(play_start), 32'd1);
        tick();
        play_finish = 1'b0;
        tick();
        check("ps_drop", 32'(play_start), 32'd0);
        repeat (len) tick();
        play_finish = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ps"},    32'(play_start), 32'd0);
        check({tag, "_start"}, 32'(start_address), 32'd0);
        check({tag, "_end"},   32'(end_address), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_full"},  32'(full), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        push = 1'b0; word = 5'd0; flush = 1'b0; play_finish = 1'b1;
        #1 reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b0;
        tick();

        // First word: code 3 plays one cycle after it is pushed.
        push_word(3);
        check("t1_count1", 32'(count), 32'd1);
        check("t1_ps_low", 32'(play_start), 32'd0);
        tick();
        check("t1_ps", 32'(play_start), 32'd1);
        check("t1_start", 32'(start_address), 32'h00A000);
        check("t1_end", 32'(end_address), 32'h00BFFF);
        check("t1_count0", 32'(count), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);

        // Handshake timing and gap spacing to a second queued word.
        push = 1'b1; word = 5'd7;
        tick();
        push = 1'b0;
        check("t2_ps_hold", 32'(play_start), 32'd1);
        check("t2_count", 32'(count), 32'd1);
        tick();
        play_finish = 1'b0;
        tick();
        check("t2_ps_drop", 32'(play_start), 32'd0);
        repeat (100) tick();
        check("t2_ps_play", 32'(play_start), 32'd0);
        check("t2_start_held", 32'(start_address), 32'h00A000);
        play_finish = 1'b1;
        wait_start(k);
        check("t2_spacing", 32'(k), 32'(GAP + 2));
        check("t2_start7", 32'(start_address), 32'(saddr(7)));
        check("t2_end7", 32'(end_address), 32'(eaddr(7)));
        play_cycle(20);
        wait_idle();

        // Fill the queue while the FSM is stalled in START.
        base = starts;
        push_word(0);
        tick();
        check("t3_start0", 32'(start_address), 32'(saddr(0)));
        for (int i = 0; i < 9; i++) begin
            push = 1'b1;
            word = 5'(codes[i]);
            tick();
            if (i == 6) check("t3_not_full7", 32'(full), 32'd0);
            if (i == 7) check("t3_full8", 32'(full), 32'd1);
        end
        push = 1'b0;
        check("t3_full9", 32'(full), 32'd1);
        check("t3_count9", 32'(count), 32'd8);
        play_cycle(5);
        for (int i = 0; i < 8; i++) begin
            wait_start(k);
            check($sformatf("t3_start_%0d", i), 32'(start_address), 32'(saddr(codes[i])));
            check($sformatf("t3_end_%0d", i), 32'(end_address), 32'(eaddr(codes[i])));
            play_cycle(5);
        end
        wait_idle();
        repeat (3) tick();
        check("t3_play_total", 32'(starts - base), 32'd9);
        check("t3_empty", 32'(count), 32'd0);

        // Invalid code 31 is skipped; word 5 starts on the next cycle.
        push_word(2);
        push = 1'b1; word = 5'd31;
        tick();
        word = 5'd5;
        tick();
        push = 1'b0;
        check("t4_count2", 32'(count), 32'd2);
        check("t4_start2", 32'(start_address), 32'(saddr(2)));
        play_cycle(5);
        k = 0;
        do begin
            tick();
            k++;
        end while (count != 4'd1 && k < 100);
        check("t4_skip_count", 32'(count), 32'd1);
        check("t4_skip_no_ps", 32'(play_start), 32'd0);
        tick();
        check("t4_ps5", 32'(play_start), 32'd1);
        check("t4_start5", 32'(start_address), 32'(saddr(5)));
        check("t4_end5", 32'(end_address), 32'(eaddr(5)));
        check("t4_count0", 32'(count), 32'd0);
        play_cycle(5);
        wait_idle();

        // Flush during PLAY with four queued and a simultaneous push.
        repeat (3) tick();
        base = starts;
        push_word(1);
        tick();
        push_word(4); push_word(5); push_word(6); push_word(7);
        check("t5_count4", 32'(count), 32'd4);
        tick();
        play_finish = 1'b0;
        tick();
        repeat (5) tick();
        flush = 1'b1; push = 1'b1; word = 5'd6;
        tick();
        flush = 1'b0; push = 1'b0;
        check("t5_flush_count", 32'(count), 32'd0);
        check("t5_flush_full", 32'(full), 32'd0);
        check("t5_flush_busy", 32'(busy), 32'd1);
        repeat (10) tick();
        play_finish = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (busy && k < 100);
        check("t5_busy_fall", 32'(k), 32'(GAP + 1));
        repeat (20) tick();
        check("t5_no_more_starts", 32'(starts - base), 32'd1);

        // Reset while in PLAY.
        push_word(8);
        tick();
        push_word(9);
        tick();
        play_finish = 1'b0;
        tick();
        tick();
        check("t6_in_play_count", 32'(count), 32'd1);
        #3 reset = 1'b1;
        #1 check_reset_outputs("rst_play");
        tick();
        reset = 1'b0;
        play_finish = 1'b1;

        // Reset while in GAP.
        push_word(4);
        tick();
        check("t6_start4", 32'(start_address), 32'(saddr(4)));
        play_cycle(5);
        tick(); tick(); tick();
        check("t6_gap_busy", 32'(busy), 32'd1);
        #3 reset = 1'b1;
        #1 check_reset_outputs("rst_gap");
        tick();
        reset = 1'b0;

        // Normal playback after reset.
        tick();
        push_word(13);
        check("t6_post_count1", 32'(count), 32'd1);
        tick();
        check("t6_post_ps", 32'(play_start), 32'd1);
        check("t6_post_start", 32'(start_address), 32'(saddr(13)));
        check("t6_post_end", 32'(end_address), 32'(eaddr(13)));
        check("t6_post_count0", 32'(count), 32'd0);
        play_cycle(5);
        wait_idle();
        check("t6_final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
